// File: rtl/wb_gpio_out_pkg.sv
// Shared definitions for the Wishbone GPIO output block: bus widths,
// register word offsets and the default ID constant.
package wb_gpio_out_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  localparam logic [15:0] ID_VAL_DEF = 16'hB0A1;

  localparam logic [2:0] ADR_OUT    = 3'd0;
  localparam logic [2:0] ADR_SET    = 3'd1;
  localparam logic [2:0] ADR_CLR    = 3'd2;
  localparam logic [2:0] ADR_TGL    = 3'd3;
  localparam logic [2:0] ADR_PERIOD = 3'd4;
  localparam logic [2:0] ADR_DUTY   = 3'd5;
  localparam logic [2:0] ADR_MASK   = 3'd6;
  localparam logic [2:0] ADR_ID     = 3'd7;

endpackage

// File: rtl/wb_gpio_pwm_gen.sv
// PWM generator: free-running counter 0..period, pwm high while cnt < duty.
// A shrinking period that leaves cnt above it folds cnt back to 0 next edge.
module wb_gpio_pwm_gen #(
  parameter int DW = 16
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic [DW-1:0] period,
  input  logic [DW-1:0] duty,
  output logic          pwm
);

  logic [DW-1:0] cnt;

  // counter wraps at period; >= also catches cnt stranded above a new period
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)            cnt <= '0;
    else if (cnt >= period) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign pwm = (cnt < duty);

endmodule

// File: rtl/wb_gpio_out.sv
// Wishbone B3 classic slave driving a 16-bit GPIO output register with
// set/clear/toggle strobes. Define WB_GPIO_PWM_EN to add the PWM overlay
// (PERIOD/DUTY/MASK registers and counter); otherwise 4-6 read 0.
module wb_gpio_out
  import wb_gpio_out_pkg::*;
#(
  parameter int          DW     = DW_DEF,
  parameter int          AW     = AW_DEF,
  parameter logic [15:0] ID_VAL = ID_VAL_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  output logic          wb_ack_o,
  output logic [DW-1:0] gpio_out_o
);

  logic          req;
  logic [DW-1:0] out_q;
  logic [DW-1:0] rdata;
  logic [DW-1:0] gpio_d;

  // ack in flight blocks a new request, giving one ack per two cycles
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

`ifdef WB_GPIO_PWM_EN
  logic [DW-1:0] period_q, duty_q, mask_q;
  logic          pwm;

  wb_gpio_pwm_gen #(.DW(DW)) u_pwm (
    .gclk   (wb_clk_i),
    .grst_n (wb_rst_n_i),
    .period (period_q),
    .duty   (duty_q),
    .pwm    (pwm)
  );

  assign gpio_d = (out_q & ~mask_q) | ({DW{pwm}} & mask_q);
`else
  assign gpio_d = out_q;
`endif

  // read mux; SET/CLR/TGL alias OUT, absent PWM registers read 0
  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      ADR_OUT, ADR_SET, ADR_CLR, ADR_TGL: rdata = out_q;
`ifdef WB_GPIO_PWM_EN
      ADR_PERIOD: rdata = period_q;
      ADR_DUTY:   rdata = duty_q;
      ADR_MASK:   rdata = mask_q;
`endif
      ADR_ID:     rdata = ID_VAL[DW-1:0];
      default:    rdata = '0;
    endcase
  end

  // bus handshake, register writes and read data, all on the ack edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      out_q    <= '0;
`ifdef WB_GPIO_PWM_EN
      period_q <= '0;
      duty_q   <= '0;
      mask_q   <= '0;
`endif
    end else begin
      wb_ack_o <= req;
      if (req && !wb_we_i) wb_dat_o <= rdata;
      if (req && wb_we_i) begin
        case (wb_adr_i)
          ADR_OUT: out_q <= wb_dat_i;
          ADR_SET: out_q <= out_q | wb_dat_i;
          ADR_CLR: out_q <= out_q & ~wb_dat_i;
          ADR_TGL: out_q <= out_q ^ wb_dat_i;
`ifdef WB_GPIO_PWM_EN
          ADR_PERIOD: period_q <= wb_dat_i;
          ADR_DUTY:   duty_q   <= wb_dat_i;
          ADR_MASK:   mask_q   <= wb_dat_i;
`endif
          default: ;
        endcase
      end
    end
  end

  // pin register: one cycle behind OUT/MASK updates
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) gpio_out_o <= '0;
    else             gpio_out_o <= gpio_d;
  end

endmodule

// File: tb/tb_wb_gpio_out.sv
// Directed bench for wb_gpio_out: reset, register map, handshake cadence,
// ID register and the PWM overlay (or its absence) per build.
module tb_wb_gpio_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  adr = '0;
  logic [15:0] dat_w = '0;
  logic [15:0] dat_r;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic        ack;
  logic [15:0] gpio;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_gpio_out dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_dat_o   (dat_r),
    .wb_we_i    (we),
    .wb_stb_i   (stb),
    .wb_cyc_i   (cyc),
    .wb_ack_o   (ack),
    .gpio_out_o (gpio)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc_step();
    @(posedge clk); #1;
  endtask

  // one bus transaction; returns whether ack arrived within the bound
  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [15:0] d,
                         output logic [15:0] rd, output logic acked);
    acked = 1'b0;
    adr = a; we = w; dat_w = d; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && !acked; i++) begin
      cyc_step();
      if (ack) acked = 1'b1;
    end
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    logic [15:0] rd;
    logic acked;
    wb_xfer(a, 1'b1, d, rd, acked);
    chk({tag, "_ack"}, 32'(acked), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] rd;
    logic acked;
    wb_xfer(a, 1'b0, '0, rd, acked);
    chk({tag, "_ack"}, 32'(acked), 32'd1);
    chk(tag, 32'(rd), 32'(exp));
  endtask

  task automatic count_hi(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc_step();
      if (gpio[0]) hi++;
    end
  endtask

  initial begin
    int acks, b2b, hi;
    logic prev;

    // reset state
    repeat (3) cyc_step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", 32'(dat_r), 32'd0);
    chk("rst_gpio", 32'(gpio), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc_step();

    // reset landing in the middle of a write
    wr("pre_wr", 3'd0, 16'h1234);
    cyc_step();
    chk("pre_gpio", 32'(gpio), 32'h1234);
    adr = 3'd0; we = 1'b1; dat_w = 16'hFFFF; cyc = 1'b1; stb = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_gpio", 32'(gpio), 32'd0);
    cyc_step();
    chk("midrst_ack2", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc_step();
    rd_chk("midrst_out", 3'd0, 16'h0000);

    // OUT / SET / CLR / TGL: F0 -> F3 -> E3 -> 80E2
    wr("wr_out", 3'd0, 16'h00F0);
    wr("wr_set", 3'd1, 16'h0003);
    rd_chk("rd_set", 3'd0, 16'h00F3);
    wr("wr_clr", 3'd2, 16'h0010);
    wr("wr_tgl", 3'd3, 16'h8001);
    rd_chk("rd_out", 3'd0, 16'h80E2);
    rd_chk("rd_alias_tgl", 3'd3, 16'h80E2);
    chk("gpio_out", 32'(gpio), 32'h80E2);

    // held read strobe: acks on alternate cycles only
    acks = 0; b2b = 0; prev = 1'b0;
    adr = 3'd0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc_step();
      if (ack) acks++;
      if (ack && prev) b2b++;
      prev = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    cyc_step();
    chk("held_acks", 32'(acks), 32'd3);
    chk("held_b2b", 32'(b2b), 32'd0);
    chk("held_dat", 32'(dat_r), 32'h80E2);

    // ID register is read-only
    rd_chk("id_rd", 3'd7, 16'hB0A1);
    wr("id_wr", 3'd7, 16'h5555);
    rd_chk("id_rd2", 3'd7, 16'hB0A1);
    rd_chk("id_out_kept", 3'd0, 16'h80E2);

`ifdef WB_GPIO_PWM_EN
    wr("pwm_per", 3'd4, 16'd9);
    wr("pwm_duty", 3'd5, 16'd3);
    wr("pwm_mask", 3'd6, 16'h0001);
    rd_chk("pwm_per_rd", 3'd4, 16'd9);
    rd_chk("pwm_mask_rd", 3'd6, 16'h0001);
    repeat (2) cyc_step();
    count_hi(20, hi);
    chk("pwm_3of10", 32'(hi), 32'd6);
    chk("pwm_hi_bits", 32'(gpio & 16'hFFFE), 32'h80E2);
    wr("pwm_duty0", 3'd5, 16'd0);
    repeat (2) cyc_step();
    count_hi(20, hi);
    chk("pwm_duty0", 32'(hi), 32'd0);
    wr("pwm_duty12", 3'd5, 16'd12);
    repeat (2) cyc_step();
    count_hi(20, hi);
    chk("pwm_duty12", 32'(hi), 32'd20);
`else
    wr("nopwm_per", 3'd4, 16'd5);
    rd_chk("nopwm_per_rd", 3'd4, 16'h0000);
    wr("nopwm_mask", 3'd6, 16'hFFFF);
    rd_chk("nopwm_mask_rd", 3'd6, 16'h0000);
    repeat (2) cyc_step();
    chk("nopwm_gpio", 32'(gpio), 32'h80E2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
